fp_normalize: RTL and testbench

FP_NORMALIZE -- requirements
Module: fp_normalize

---
 rtl/fp_normalize.sv | 141 ++++++++++++++
 tb/tb_fp_normalize.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalize.sv
// Floating-point post-add normalizer, two-stage pipeline with valid/ready flow control.
// Stage 1 captures the raw add/sub result and its leading-zero count.
// Stage 2 captures the packed, normalized result and the overflow/underflow flags.
module fp_normalize #(
  parameter int ex_width  = 8,
  parameter int man_width = 23
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            sign_in,
  input  logic [ex_width-1:0]             max_exp,
  input  logic [man_width+1:0]            mant_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ex_width+man_width:0]     result,
  output logic                            overflow,
  output logic                            underflow
);

  localparam int W    = man_width + 2;
  localparam int LZ_W = $clog2(W);
  localparam int EW1  = ex_width + 1;
  localparam int RW   = 1 + ex_width + man_width;

  logic                vld_p1;
  logic                sign_p1;
  logic [ex_width-1:0] exp_p1;
  logic [W-1:0]        mant_p1;
  logic [LZ_W-1:0]     lz_p1;

  logic                vld_p2;
  logic [RW-1:0]       result_p2;
  logic                ovf_p2;
  logic                unf_p2;

  logic                load_p1;
  logic                load_p2;
  logic [RW+1:0]       norm_p1;

  // Leading zeros counted from the hidden-bit position downward; carry bit ignored.
  function automatic logic [LZ_W-1:0] count_lz(input logic [W-1:0] m);
    logic [LZ_W-1:0] n;
    logic            hit;
    n   = '0;
    hit = 1'b0;
    for (int i = W - 2; i >= 0; i--) begin
      if (!hit) begin
        if (m[i]) hit = 1'b1;
        else      n = n + 1'b1;
      end
    end
    return n;
  endfunction

  // Returns {overflow, underflow, result}. Exponent math is one bit wider than the
  // field so max_exp+1 and max_exp-lz never wrap before they are compared.
  function automatic logic [RW+1:0] normalize(
    input logic                sign,
    input logic [ex_width-1:0] exp,
    input logic [W-1:0]        mant,
    input logic [LZ_W-1:0]     lz
  );
    logic [EW1-1:0]      exp_w;
    logic [EW1-1:0]      lz_w;
    logic [EW1-1:0]      exp_adj;
    logic [W-1:0]        shifted;
    logic [RW+1:0]       r;
    exp_w   = {1'b0, exp};
    lz_w    = EW1'(lz);
    exp_adj = '0;
    shifted = '0;
    r       = '0;
    if (mant == '0) begin
      r = '0;
    end else if (exp == {ex_width{1'b1}}) begin
      r = {2'b00, sign, {ex_width{1'b1}}, {man_width{1'b0}}};
    end else if (mant[W-1]) begin
      exp_adj = exp_w + 1'b1;
      if (exp_adj == {1'b0, {ex_width{1'b1}}})
        r = {2'b10, sign, {ex_width{1'b1}}, {man_width{1'b0}}};
      else
        r = {2'b00, sign, exp_adj[ex_width-1:0], mant[W-2:1]};
    end else if (lz_w >= exp_w) begin
      r = {2'b01, sign, {(RW-1){1'b0}}};
    end else begin
      exp_adj = exp_w - lz_w;
      shifted = mant << lz;
      r = {2'b00, sign, exp_adj[ex_width-1:0], shifted[W-3:0]};
    end
    return r;
  endfunction

  assign load_p2  = !vld_p2 || out_ready;
  assign load_p1  = !vld_p1 || load_p2;
  assign in_ready = load_p1;
  assign norm_p1  = normalize(sign_p1, exp_p1, mant_p1, lz_p1);

  // ---- stage 1: capture raw inputs and leading-zero count ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      sign_p1 <= 1'b0;
      exp_p1  <= '0;
      mant_p1 <= '0;
      lz_p1   <= '0;
    end else if (load_p1) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        sign_p1 <= sign_in;
        exp_p1  <= max_exp;
        mant_p1 <= mant_in;
        lz_p1   <= count_lz(mant_in);
      end
    end
  end

  // ---- stage 2: capture normalized result and flags; held while stalled ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2    <= 1'b0;
      result_p2 <= '0;
      ovf_p2    <= 1'b0;
      unf_p2    <= 1'b0;
    end else if (load_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        ovf_p2    <= norm_p1[RW+1];
        unf_p2    <= norm_p1[RW];
        result_p2 <= norm_p1[RW-1:0];
      end
    end
  end

  assign out_valid = vld_p2;
  assign result    = result_p2;
  assign overflow  = ovf_p2;
  assign underflow = unf_p2;

endmodule

// File: tb/tb_fp_normalize.sv
// Bench for fp_normalize (ex_width=8, man_width=23): directed and random beats,
// expected results queued at acceptance and compared in order at output handshake.
module tb_fp_normalize;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [7:0]  max_exp;
  logic [24:0] mant_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t q[$];
  exp_t pend;
  exp_t head;
  exp_t held;
  logic held_v;
  logic accepted;
  int   vectors     = 0;
  int   miscompares = 0;

  fp_normalize #(.ex_width(8), .man_width(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .max_exp   (max_exp),
    .mant_in   (mant_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic s, input logic [7:0] e, input logic [24:0] m);
    exp_t        r;
    int          lz;
    logic [24:0] sh;
    r  = '0;
    lz = 0;
    sh = '0;
    if (m == 25'd0) begin
      r = '0;
    end else if (e == 8'hFF) begin
      r.res = {s, 8'hFF, 23'h0};
    end else if (m[24]) begin
      if (e == 8'hFE) begin
        r.res = {s, 8'hFF, 23'h0};
        r.ovf = 1'b1;
      end else begin
        r.res = {s, e + 8'd1, m[23:1]};
      end
    end else begin
      while (!m[23 - lz]) lz++;
      if (lz >= int'(e)) begin
        r.res = {s, 31'h0};
        r.unf = 1'b1;
      end else begin
        sh    = m << lz;
        r.res = {s, 8'(int'(e) - lz), sh[22:0]};
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s observed %h expected %h", tag, got, want);
    end
  endtask

  // One clock: inspect handshakes at the falling edge, then advance past the rising edge.
  task automatic tick();
    @(negedge clk);
    accepted = 1'b0;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_output observed %h expected none", result);
      end else begin
        head = q.pop_front();
        check("result", {result, overflow, underflow}, {head.res, head.ovf, head.unf});
      end
      held_v = 1'b0;
    end else if (out_valid && !out_ready) begin
      if (held_v) check("stall_hold", {result, overflow, underflow}, {held.res, held.ovf, held.unf});
      held   = '{res: result, ovf: overflow, unf: underflow};
      held_v = 1'b1;
    end else begin
      held_v = 1'b0;
    end
    if (in_valid && in_ready) begin
      q.push_back(pend);
      accepted = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic s, input logic [7:0] e, input logic [24:0] m, input exp_t want);
    sign_in  = s;
    max_exp  = e;
    mant_in  = m;
    pend     = want;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    tick();
    while (!accepted && n < 20) begin
      out_ready = 1'b1;
      tick();
      n++;
    end
    if (!accepted) check("accept_timeout", 34'd0, 34'd1);
  endtask

  task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m, input exp_t want);
    set_beat(s, e, m, want);
    wait_accept();
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    if (q.size() != 0) check("drain_timeout", 34'(q.size()), 34'd0);
  endtask

  initial begin
    logic [24:0] rm;
    exp_t        rw;
    held_v    = 1'b0;
    accepted  = 1'b0;
    pend      = '0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sign_in   = 1'b0;
    max_exp   = '0;
    mant_in   = '0;
    #2;
    check("reset_state", {out_valid, in_ready, overflow, underflow, 30'd0}, {4'b0100, 30'd0});
    check("reset_result", {2'b00, result}, 34'd0);
    tick();
    tick();
    rst = 1'b0;

    // 1.0 passthrough and two-cycle latency
    send(1'b0, 8'd127, 25'h0800000, '{res: 32'h3F800000, ovf: 1'b0, unf: 1'b0});
    in_valid = 1'b0;
    check("latency_not_yet", {33'd0, out_valid}, 34'd0);
    tick();
    check("latency_two", {33'd0, out_valid}, 34'd1);
    drain();

    // carry normalization and exponent overflow
    send(1'b0, 8'd127, 25'h1000000, '{res: 32'h40000000, ovf: 1'b0, unf: 1'b0});
    send(1'b0, 8'd254, 25'h1000000, '{res: 32'h7F800000, ovf: 1'b1, unf: 1'b0});
    // deep left shift and exponent underflow
    send(1'b0, 8'd127, 25'h0000001, '{res: 32'h34000000, ovf: 1'b0, unf: 1'b0});
    send(1'b1, 8'd3,   25'h0000001, '{res: 32'h80000000, ovf: 1'b0, unf: 1'b1});
    // zero magnitude, and saturated input exponent
    send(1'b1, 8'd100, 25'h0000000, '{res: 32'h00000000, ovf: 1'b0, unf: 1'b0});
    send(1'b1, 8'hFF,  25'h0812345, '{res: 32'hFF800000, ovf: 1'b0, unf: 1'b0});
    // lz exactly equal to max_exp underflows; one below does not
    send(1'b0, 8'd2,   25'h0200000, '{res: 32'h00000000, ovf: 1'b0, unf: 1'b1});
    send(1'b0, 8'd3,   25'h0300000, '{res: 32'h00C00000, ovf: 1'b0, unf: 1'b0});
    drain();

    // backpressure: two accepted, third held off, results held, order preserved
    out_ready = 1'b0;
    send(1'b0, 8'd127, 25'h0800000, '{res: 32'h3F800000, ovf: 1'b0, unf: 1'b0});
    send(1'b0, 8'd128, 25'h0C00000, '{res: 32'h40400000, ovf: 1'b0, unf: 1'b0});
    set_beat(1'b1, 8'd129, 25'h1800000, '{res: 32'hC1400000, ovf: 1'b0, unf: 1'b0});
    check("in_ready_drop", {33'd0, in_ready}, 34'd0);
    check("stall_first", {result, overflow, underflow}, {32'h3F800000, 2'b00});
    tick();
    tick();
    tick();
    check("stall_no_accept", {33'd0, accepted}, 34'd0);
    out_ready = 1'b1;
    wait_accept();
    drain();

    // random beats with random backpressure
    for (int i = 0; i < 40; i++) begin
      rm = 25'($urandom) >> $urandom_range(0, 24);
      sign_in = 1'b0;
      rw = model(1'($urandom), 8'($urandom), rm);
      out_ready = 1'($urandom);
      set_beat(rw.res[31], 8'($urandom_range(0, 255)), rm, '0);
      pend = model(sign_in, max_exp, mant_in);
      wait_accept();
      check("flags_exclusive", {32'd0, pend.ovf & pend.unf, overflow & underflow}, 34'd0);
    end
    drain();

    // asynchronous reset with both stages full discards everything in flight
    out_ready = 1'b0;
    send(1'b0, 8'd10, 25'h0900000, '{res: 32'h05100000, ovf: 1'b0, unf: 1'b0});
    send(1'b0, 8'd11, 25'h0900000, '{res: 32'h05900000, ovf: 1'b0, unf: 1'b0});
    in_valid = 1'b0;
    check("full_before_reset", {33'd0, out_valid}, 34'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_clear", {out_valid, overflow, result, underflow}, 34'd0);
    check("reset_in_ready", {33'd0, in_ready}, 34'd1);
    q.delete();
    held_v = 1'b0;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("no_stale_beat", {33'd0, out_valid}, 34'd0);
    end

    // first beat after reset is accepted on the first edge
    set_beat(1'b0, 8'd127, 25'h0800000, '{res: 32'h3F800000, ovf: 1'b0, unf: 1'b0});
    tick();
    check("first_accept", {33'd0, accepted}, 34'd1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
